// File: rtl/fp_mult_pkg.sv
// Shared single-precision float types, constants and classification helpers
// used by the fp_mult pipeline.
package floatingpoint;

   localparam int          FP_BIAS    = 127;
   localparam int          FP_EXP_MAX = 255;
   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } float;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // Result category decided up front, so later stages only do the normal-case maths.
   typedef enum logic [1:0] {
      CLS_NORMAL,
      CLS_ZERO,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   function automatic logic IsZero(input float f);
      return (f.exp == 8'd0) && (f.man == 23'd0);
   endfunction

   function automatic logic IsInf(input float f);
      return (f.exp == 8'hFF) && (f.man == 23'd0);
   endfunction

   function automatic logic IsNaN(input float f);
      return (f.exp == 8'hFF) && (f.man != 23'd0);
   endfunction

   function automatic logic IsDenorm(input float f);
      return (f.exp == 8'd0) && (f.man != 23'd0);
   endfunction

endpackage

// File: rtl/fp_mult_round_pack.sv
// Normalize, round-to-nearest-even and pack the raw 48-bit product into a float,
// resolving special classes and exponent overflow/underflow.
module fp_round_pack
   import floatingpoint::*;
(
   input  logic              sign_i,
   input  fp_class_e         cls_i,
   input  logic signed [9:0] exp_i,
   input  logic [47:0]       prod_i,
   output float              result_o,
   output fp_flags_t         flags_o
);

   localparam logic signed [9:0] EXP_MAX10 = 10'(FP_EXP_MAX);

   logic [22:0]       frac;
   logic              guardBit;
   logic              stickyBit;
   logic              roundUp;
   logic [23:0]       mantRnd;
   logic signed [9:0] expAdj;
   logic signed [9:0] expFinal;

   always_comb begin
      result_o  = '0;
      flags_o   = '0;
      frac      = prod_i[45:23];
      guardBit  = prod_i[22];
      stickyBit = |prod_i[21:0];
      expAdj    = exp_i;

      // Product of two 1.x mantissas lies in [1,4); a set top bit means one extra shift.
      if (prod_i[47]) begin
         frac      = prod_i[46:24];
         guardBit  = prod_i[23];
         stickyBit = |prod_i[22:0];
         expAdj    = exp_i + 10'sd1;
      end

      roundUp  = guardBit & (stickyBit | frac[0]);
      mantRnd  = {1'b0, frac} + {23'd0, roundUp};
      expFinal = mantRnd[23] ? (expAdj + 10'sd1) : expAdj;

      case (cls_i)
         CLS_NAN: begin
            result_o        = FP_QNAN;
            flags_o.invalid = 1'b1;
         end
         CLS_INF:  result_o = {sign_i, 8'hFF, 23'd0};
         CLS_ZERO: result_o = {sign_i, 31'd0};
         default: begin
            if (expFinal >= EXP_MAX10) begin
               result_o         = {sign_i, 8'hFF, 23'd0};
               flags_o.overflow = 1'b1;
               flags_o.inexact  = 1'b1;
            end else if (expFinal <= 10'sd0) begin
               result_o          = {sign_i, 31'd0};
               flags_o.underflow = 1'b1;
               flags_o.inexact   = 1'b1;
            end else begin
               result_o        = {sign_i, expFinal[7:0], mantRnd[22:0]};
               flags_o.inexact = guardBit | stickyBit;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mult.sv
// Three-stage single-precision multiplier: classify/unpack, mantissa multiply,
// normalize/round/pack. The whole pipeline stalls when the output is blocked.
module fp_mult
   import floatingpoint::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      in_valid,
   output logic      in_ready,
   input  float      a,
   input  float      b,
   output logic      out_valid,
   input  logic      out_ready,
   output float      result,
   output fp_flags_t flags
);

   localparam logic signed [9:0] BIAS10 = 10'(FP_BIAS);

   logic advance;

   float      aFlush;
   float      bFlush;
   logic      s1Sign_d;
   fp_class_e s1Cls_d;

   logic        s1Valid_q;
   logic        s1Sign_q;
   fp_class_e   s1Cls_q;
   logic [7:0]  s1ExpA_q;
   logic [7:0]  s1ExpB_q;
   logic [23:0] s1ManA_q;
   logic [23:0] s1ManB_q;

   logic signed [9:0] s2Exp_d;
   logic [47:0]       s2Prod_d;

   logic              s2Valid_q;
   logic              s2Sign_q;
   fp_class_e         s2Cls_q;
   logic signed [9:0] s2Exp_q;
   logic [47:0]       s2Prod_q;

   float      s3Result_d;
   fp_flags_t s3Flags_d;

   logic      s3Valid_q;
   float      result_q;
   fp_flags_t flags_q;

   assign advance  = !(s3Valid_q && !out_ready);
   assign in_ready = advance;

   // Denormals become signed zeros before any classification is made.
   always_comb begin
      aFlush = a;
      bFlush = b;
      if (IsDenorm(a)) aFlush = {a.sign, 31'd0};
      if (IsDenorm(b)) bFlush = {b.sign, 31'd0};

      s1Sign_d = aFlush.sign ^ bFlush.sign;
      if (IsNaN(aFlush) || IsNaN(bFlush) ||
          (IsZero(aFlush) && IsInf(bFlush)) || (IsInf(aFlush) && IsZero(bFlush)))
         s1Cls_d = CLS_NAN;
      else if (IsInf(aFlush) || IsInf(bFlush))
         s1Cls_d = CLS_INF;
      else if (IsZero(aFlush) || IsZero(bFlush))
         s1Cls_d = CLS_ZERO;
      else
         s1Cls_d = CLS_NORMAL;
   end

   always_comb begin
      s2Exp_d  = $signed({2'b00, s1ExpA_q}) + $signed({2'b00, s1ExpB_q}) - BIAS10;
      s2Prod_d = 48'(s1ManA_q) * 48'(s1ManB_q);
   end

   fp_round_pack u_round_pack (
      .sign_i   (s2Sign_q),
      .cls_i    (s2Cls_q),
      .exp_i    (s2Exp_q),
      .prod_i   (s2Prod_q),
      .result_o (s3Result_d),
      .flags_o  (s3Flags_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Sign_q  <= 1'b0;
         s1Cls_q   <= CLS_ZERO;
         s1ExpA_q  <= '0;
         s1ExpB_q  <= '0;
         s1ManA_q  <= '0;
         s1ManB_q  <= '0;
         s2Valid_q <= 1'b0;
         s2Sign_q  <= 1'b0;
         s2Cls_q   <= CLS_ZERO;
         s2Exp_q   <= '0;
         s2Prod_q  <= '0;
         s3Valid_q <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
      end else if (advance) begin
         s1Valid_q <= in_valid;
         s1Sign_q  <= s1Sign_d;
         s1Cls_q   <= s1Cls_d;
         s1ExpA_q  <= aFlush.exp;
         s1ExpB_q  <= bFlush.exp;
         s1ManA_q  <= {1'b1, aFlush.man};
         s1ManB_q  <= {1'b1, bFlush.man};
         s2Valid_q <= s1Valid_q;
         s2Sign_q  <= s1Sign_q;
         s2Cls_q   <= s1Cls_q;
         s2Exp_q   <= s2Exp_d;
         s2Prod_q  <= s2Prod_d;
         s3Valid_q <= s2Valid_q;
         result_q  <= s3Result_d;
         flags_q   <= s3Flags_d;
      end
   end

   assign out_valid = s3Valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mult.sv
// Self-checking bench for fp_mult: integer reference model, scoreboard monitor,
// directed literal vectors, backpressure stream, mid-flight reset and random traffic.
module tb_fp_mult;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int stallCount = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      int          accCycle;
      int          accStall;
   } exp_t;

   exp_t sbq[$];

   logic        holdPrev = 1'b0;
   logic [31:0] heldRes;
   logic [3:0]  heldFl;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   fp_mult dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   // Reference: returns {flags, result} using exact integer arithmetic on the operands.
   function automatic logic [35:0] refMul(input logic [31:0] x, input logic [31:0] y);
      logic   sx, sy, sgn;
      int     ex, ey, e, sh;
      longint mx, my, p, kept, rem, half;
      logic   xNan, yNan, xInf, yInf, xZero, yZero, inexact;
      sx = x[31]; ex = int'(x[30:23]); mx = longint'(x[22:0]);
      sy = y[31]; ey = int'(y[30:23]); my = longint'(y[22:0]);
      sgn   = sx ^ sy;
      xNan  = (ex == 255) && (mx != 0);
      yNan  = (ey == 255) && (my != 0);
      xInf  = (ex == 255) && (mx == 0);
      yInf  = (ey == 255) && (my == 0);
      xZero = (ex == 0);
      yZero = (ey == 0);
      if (xNan || yNan || (xZero && yInf) || (xInf && yZero))
         return {4'b1000, 32'h7FC00000};
      if (xInf || yInf)
         return {4'b0000, sgn, 8'hFF, 23'd0};
      if (xZero || yZero)
         return {4'b0000, sgn, 31'd0};
      p  = ((64'd1 << 23) + mx) * ((64'd1 << 23) + my);
      e  = ex + ey - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = e + sh - 23;
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         e = e + 1;
      end
      if (e >= 255) return {4'b0101, sgn, 8'hFF, 23'd0};
      if (e <= 0)   return {4'b0011, sgn, 31'd0};
      return {3'b000, inexact, sgn, e[7:0], kept[22:0]};
   endfunction

   function automatic logic [31:0] randOp();
      logic [31:0] r;
      logic [7:0]  ex;
      int          sel;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
         0: return {r[31], 31'd0};
         1: return {r[31], 8'hFF, 23'd0};
         2: return {r[31], 8'hFF, r[22:1], 1'b1};
         3: return {r[31], 8'd0, r[22:1], 1'b1};
         4: ex = 8'($urandom_range(235, 254));
         5: ex = 8'($urandom_range(1, 20));
         6: ex = 8'($urandom_range(120, 134));
         default: ex = 8'($urandom_range(1, 254));
      endcase
      return {r[31], ex, r[22:0]};
   endfunction

   // Scoreboard monitor, sampled on the falling edge away from DUT updates.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sbq.delete();
         holdPrev = 1'b0;
      end else begin
         checkOutput("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (holdPrev) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", 64'(result), 64'(heldRes));
            checkOutput("hold_flags", 64'(flags), 64'(heldFl));
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checkOutput("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
               e = sbq.pop_front();
               checkOutput("result", 64'(result), 64'(e.res));
               checkOutput("flags", 64'(flags), 64'(e.fl));
               checkOutput("latency", 64'(cycle),
                           64'(e.accCycle + 3 + (stallCount - e.accStall)));
            end
         end
         if (out_valid && !out_ready) begin
            stallCount++;
            holdPrev = 1'b1;
            heldRes  = result;
            heldFl   = flags;
         end else begin
            holdPrev = 1'b0;
         end
         if (in_valid && in_ready) begin
            logic [35:0] m;
            m = refMul(a, b);
            e.res = m[31:0];
            e.fl  = m[35:32];
            e.accCycle = cycle;
            e.accStall = stallCount;
            sbq.push_back(e);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic runDirected(input string nm, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] expRes, input logic [3:0] expFl);
      logic [35:0] m;
      int n;
      m = refMul(x, y);
      checkOutput({nm, "_model"}, 64'(m), 64'({expFl, expRes}));
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      applyStimulus(x, y);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({nm, "_latency"}, 64'(n), 64'd2);
      checkOutput({nm, "_result"}, 64'(result), 64'(expRes));
      checkOutput({nm, "_flags"}, 64'(flags), 64'(expFl));
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int sent, k, guard;
      logic acc;

      doReset();
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_result", 64'(result), 64'd0);
      checkOutput("reset_flags", 64'(flags), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

      runDirected("mul_1p5_2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
      runDirected("mul_neg", 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
      runDirected("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
      runDirected("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
      runDirected("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
      runDirected("denorm", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
      runDirected("rne", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
      runDirected("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
      runDirected("neg_zero", 32'h80000000, 32'h7F000000, 32'h80000000, 4'b0000);

      // Eight back-to-back operands under a 1,0,0,1 out_ready pattern.
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      sent = 0; k = 0; guard = 0;
      in_valid = 1'b1;
      a = randOp();
      b = randOp();
      while (sent < 8 && guard < 200) begin
         out_ready = (k % 4 == 0) || (k % 4 == 3);
         k++;
         guard++;
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            a = randOp();
            b = randOp();
            if (sent == 8) in_valid = 1'b0;
         end
      end
      checkOutput("stream_sent", 64'(sent), 64'd8);
      in_valid = 1'b0;
      repeat (12) begin
         out_ready = (k % 4 == 0) || (k % 4 == 3);
         k++;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("stream_drained", 64'(sbq.size()), 64'd0);

      // Reset with three operands in flight.
      applyStimulus(32'h3F800000, 32'h40000000);
      in_valid = 1'b1; a = 32'h40400000; b = 32'h40400000;
      @(posedge clk); #1;
      a = 32'hC1200000; b = 32'h3F000000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("post_reset_idle", 64'(out_valid), 64'd0);
         @(posedge clk); #1;
      end
      runDirected("after_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

      // Random traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = randOp();
         b = randOp();
         @(posedge clk);
         #1;
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (sbq.size() != 0 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("final_drain", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_mult.md
FP_MULT -- requirements
Module: fp_mult

Interface
REQ-001 Parameter: none; latency fixed at 3 cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b present this cycle.
REQ-005 in_ready  output  1  block accepts operands; transfer when in_valid && in_ready.
REQ-006 a  input  32 (float)  multiplicand, IEEE-754 single, packed float struct from package floatingpoint.
REQ-007 b  input  32 (float)  multiplier, same format.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-010 result  output  32 (float)  a*b, rounded.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-012 Pipeline of 3 registered stages S1 (classify/unpack), S2 (24x24 mantissa multiply, exponent sum), S3 (normalize/round/pack); each stage holds a valid bit.
REQ-013 Accepted operand appears on result exactly 3 cycles after acceptance when out_ready stays high.
REQ-014 Throughput one result per cycle with no backpressure.
REQ-015 in_ready = !(S3 valid && !out_ready); when low, all stages hold (whole-pipeline stall), no bubble compression required.
REQ-016 Input accepted in a stall cycle is forbidden by construction (in_ready low); in_valid ignored while in_ready low.
REQ-017 Results leave in acceptance order; no reordering, no drop, no duplication.
REQ-018 Sign = a.sign XOR b.sign for all cases including zero and inf.
REQ-019 Denormal inputs flushed to signed zero before classification.
REQ-020 Either operand NaN, or zero times inf: result canonical qNaN 32'h7FC00000, invalid=1.
REQ-021 Inf times nonzero finite or inf: signed inf, no flags.
REQ-022 Zero times finite: signed zero, no flags.
REQ-023 Normal case: exponent = ea + eb - 127 (10-bit signed intermediate), 48-bit product; if product bit 47 set, shift right 1 and exponent +1.
REQ-024 Rounding round-to-nearest-even using guard bit and sticky OR of remaining bits; mantissa carry-out renormalizes and increments exponent.
REQ-025 inexact=1 when guard or sticky nonzero.
REQ-026 Final exponent >= 255: signed inf, overflow=1, inexact=1.
REQ-027 Final exponent <= 0: signed zero (flush-to-zero), underflow=1, inexact=1.
REQ-028 result and flags hold stable while out_valid && !out_ready.

Reset
REQ-029 While rst_n low at a clock edge: all stage valid bits clear, out_valid=0, result=0, flags=0, in_ready=1 on first cycle after release.
REQ-030 Reset mid-operation discards all in-flight operands; no result emitted for them.

Structure
REQ-031 Package floatingpoint gains FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000 and a flags struct typedef; fp_mult imports float, IsZero, IsInf, IsNaN, IsDenorm.
REQ-032 One sub-module fp_round_pack (combinational, S3 normalize/round/pack with overflow/underflow detection); multiply and classification stay in fp_mult.

Verification
REQ-033 a=3FC00000 (1.5), b=40000000 (2.0), out_ready=1 -> result 40400000, flags 0000, 3 cycles after acceptance.
REQ-034 a=C0000000, b=40400000 -> C0C00000; a=7F800000, b=00000000 -> 7FC00000, invalid=1.
REQ-035 a=7F7FFFFF, b=40000000 -> 7F800000, overflow=1, inexact=1; a=00800000, b=3F000000 -> 00000000, underflow=1; a=00000001, b=40000000 -> 00000000, flags 0000.
REQ-036 a=3F800001, b=3F800001 -> 3F800002, inexact=1 (round-to-nearest-even).
REQ-037 Stream 8 back-to-back operands, out_ready toggled 1,0,0,1,... -> 8 in-order results, each held stable during stall, in_ready low exactly while S3 valid and out_ready low.
REQ-038 Assert rst_n low with 3 operands in flight -> no out_valid for them after release; next operand yields correct result at latency 3.
